te_radio_enable_ctrl: RTL and testbench

- Timing-engine end of the radio-enable handshake. Drives `radioEnableSynced` toward the M2 domain.
- Watches the registered `radioEnable` that M2 returns.
- Runs one timed radio-on window per start request: settle delay, assert, acknowledge, active count, release, drop confirmation.
- Flags lost or stuck acknowledgements; honours M1/M2 isolation.

---
 rtl/te_radio_pkg.sv | 19 +
 rtl/te_sync_bit.sv | 32 +++
 rtl/te_radio_enable_ctrl.sv | 179 +++++++++++++++++
 tb/tb_te_radio_enable_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/te_radio_pkg.sv
// Shared types and default timing constants for the timing-engine radio-enable handshake.
//   te_radio_state_e  : handshake controller state encoding
//   *Default          : default values for the controller timing parameters
package te_radio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StWaitAck,
    StActive,
    StWaitDrop,
    StError
  } te_radio_state_e;

  localparam int unsigned SettleCycDefault  = 4;
  localparam int unsigned AckTimeoutDefault = 8;
  localparam int unsigned SyncStagesDefault = 2;

endpackage

// File: rtl/te_sync_bit.sv
// N-flop single-bit synchroniser with asynchronous active-low reset to 0.
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input bit
//   q_o    : synchronised output (Stages cycles of latency)
module te_sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/te_radio_enable_ctrl.sv
// Timing-engine side of the radio-enable handshake. Opens one timed radio-on window per
// accepted start: settle, raise the request, wait for the synchronised feedback, hold for the
// programmed length, drop the request and wait for the feedback to fall.
//   ck / arst_n          : clock, asynchronous active-low reset
//   isolateM1M2          : isolation active, request must be released
//   start_i / stop_i     : open a window / terminate the active window early
//   on_cycles_i          : window length, sampled at an accepted start
//   radioEnable_i        : M2's registered radioEnable (asynchronous to this logic)
//   radioEnableSynced_o  : enable request toward M2
//   busy_o / active_o    : not idle / in the on-window
//   done_o               : one-cycle pulse on window completion
//   err_o / err_clr_i    : sticky handshake error and its clear
module te_radio_enable_ctrl
  import te_radio_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SETTLE_CYC  = SettleCycDefault,
  parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             isolateM1M2,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] on_cycles_i,
  input  logic             radioEnable_i,
  output logic             radioEnableSynced_o,
  output logic             busy_o,
  output logic             active_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SetW-1:0]  SettleLast = SetW'(SETTLE_CYC - 1);
  localparam logic [ToW-1:0]   ToLast     = ToW'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WinOne     = CNT_W'(1);

  te_radio_state_e  state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fb;
  logic             start_ok;

  te_sync_bit #(
    .Stages (SYNC_STAGES)
  ) u_fb_sync (
    .clk_i  (ck),
    .rst_ni (arst_n),
    .d_i    (radioEnable_i),
    .q_o    (fb)
  );

  assign start_ok = (state_q == StIdle) && start_i && !isolateM1M2 && !err_q;

  // State and registered outputs.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      to_q     <= '0;
      win_q    <= '0;
      len_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      to_q     <= to_d;
      win_q    <= win_d;
      len_q    <= len_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counters. Counters only step while below their terminal value.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    to_d     = to_q;
    win_d    = win_q;
    len_d    = len_q;
    unique case (state_q)
      StIdle: begin
        settle_d = '0;
        to_d     = '0;
        if (start_ok && (on_cycles_i != '0)) begin
          len_d   = on_cycles_i;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (isolateM1M2) begin
          to_d    = '0;
          state_d = StWaitDrop;
        end else if (settle_q >= SettleLast) begin
          to_d    = '0;
          state_d = StWaitAck;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      StWaitAck: begin
        // Isolation beats both the acknowledge and the timeout: release without error.
        if (isolateM1M2) begin
          to_d    = '0;
          state_d = StWaitDrop;
        end else if (fb) begin
          win_d   = len_q;
          state_d = StActive;
        end else if (to_q >= ToLast) begin
          state_d = StError;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StActive: begin
        // Exit on the count's last cycle so the window lasts exactly on_cycles_i cycles;
        // a coincident stop_i yields the same single exit.
        if (isolateM1M2 || stop_i || (win_q <= WinOne)) begin
          to_d    = '0;
          state_d = StWaitDrop;
        end else begin
          win_d = win_q - WinOne;
        end
      end
      StWaitDrop: begin
        if (!fb) begin
          state_d = StIdle;
        end else if (to_q >= ToLast) begin
          state_d = StError;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StError: begin
        if (err_clr_i && !fb) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next values, derived from the state being entered so every output is a flop.
  always_comb begin
    req_d    = (state_d == StWaitAck) || (state_d == StActive);
    busy_d   = (state_d != StIdle);
    active_d = (state_d == StActive);
    err_d    = (state_d == StError);
    done_d   = ((state_q == StWaitDrop) && (state_d == StIdle)) ||
               (start_ok && (on_cycles_i == '0));
  end

  assign radioEnableSynced_o = req_q;
  assign busy_o              = busy_q;
  assign active_o            = active_q;
  assign done_o              = done_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_te_radio_enable_ctrl.sv
// Bench for te_radio_enable_ctrl. Each window is planned as a set of edge numbers (relative to
// the edge that samples start_i) derived from the handshake timing rules; expected outputs at
// every edge follow from those numbers. M2 is modelled as one register on the request.
module tb_te_radio_enable_ctrl;

  localparam int CntW = 16;
  localparam int S    = 4;  // settle cycles
  localparam int Y    = 2;  // synchroniser stages
  localparam int T    = 8;  // acknowledge timeout

  localparam int MNormal    = 0;
  localparam int MStop      = 1;
  localparam int MIsoAct    = 2;
  localparam int MZero      = 3;
  localparam int MIsoSettle = 4;
  localparam int MStuckLow  = 5;
  localparam int MStuckHigh = 6;

  logic            ck        = 1'b0;
  logic            arst_n    = 1'b1;
  logic            isolate   = 1'b0;
  logic            start     = 1'b0;
  logic            stop      = 1'b0;
  logic            err_clr   = 1'b0;
  logic [CntW-1:0] on_cycles = '0;
  logic            radio_en;
  logic            req, busy, active, done, err;
  logic            m2_q      = 1'b0;
  logic            force_en  = 1'b0;
  logic            force_val = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  // Window plan: edge numbers at which things happen (-1 = never).
  int p_a, p_x, p_d, p_err, p_clr, p_req_end, p_busy_end, p_last;

  always #5 ck = ~ck;

  // M2's registered copy of the request.
  always @(posedge ck) m2_q <= req;

  assign radio_en = force_en ? force_val : m2_q;

  te_radio_enable_ctrl #(
    .CNT_W       (CntW),
    .SETTLE_CYC  (S),
    .ACK_TIMEOUT (T),
    .SYNC_STAGES (Y)
  ) dut (
    .ck                  (ck),
    .arst_n              (arst_n),
    .isolateM1M2         (isolate),
    .start_i             (start),
    .stop_i              (stop),
    .on_cycles_i         (on_cycles),
    .radioEnable_i       (radio_en),
    .radioEnableSynced_o (req),
    .busy_o              (busy),
    .active_o            (active),
    .done_o              (done),
    .err_o               (err),
    .err_clr_i           (err_clr)
  );

  function automatic logic [4:0] exp_out(input int e);
    logic r, b, a, d, x;
    r = (e >= S) && (e < p_req_end);
    b = (e < p_busy_end);
    a = (p_a >= 0) && (e >= p_a) && (e < p_x);
    d = (e == p_d);
    x = (p_err >= 0) && (e >= p_err) && (e < p_clr);
    return {r, b, a, d, x};
  endfunction

  task automatic check(input string tag, input int e, input logic [4:0] exp);
    logic [4:0] got;
    got = {req, busy, active, done, err};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s e=%0d: req/busy/act/done/err got %b expected %b", tag, e, got, exp);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      stop    = 1'b0;
      isolate = 1'b0;
      err_clr = 1'b0;
      @(posedge ck);
      #1;
      check(tag, i, 5'b0);
    end
  endtask

  task automatic run_window(input int mode, input int n, input int k, input int stop_at,
                            input string tag);
    logic iso_mode;
    iso_mode   = (mode == MIsoAct) || (mode == MIsoSettle);
    p_a        = -1;
    p_x        = 0;
    p_d        = -1;
    p_err      = -1;
    p_clr      = -1;
    p_req_end  = 0;
    p_busy_end = 0;
    case (mode)
      MNormal, MStop, MIsoAct: begin
        p_a        = S + Y + 2;  // request, M2 register, Y sync flops, FSM decision
        p_x        = p_a + ((mode == MNormal) ? n : k);
        p_req_end  = p_x;
        p_d        = p_x + Y + 2;
        p_busy_end = p_d;
      end
      MZero: begin
        p_d = 0;
      end
      MIsoSettle: begin
        p_x        = k;
        p_req_end  = k;
        p_d        = k + 1;
        p_busy_end = p_d;
      end
      MStuckLow: begin
        p_req_end  = S + T;
        p_err      = S + T;
        p_clr      = p_err + 1 + k;
        p_busy_end = p_clr;
      end
      default: begin  // MStuckHigh: feedback already high when the request rises
        p_a        = S + 1;
        p_x        = p_a + n;
        p_req_end  = p_x;
        p_err      = p_x + T;
        p_clr      = p_err + 5;
        p_busy_end = p_clr;
      end
    endcase
    p_last = ((p_busy_end > p_d) ? p_busy_end : p_d) + 2;

    if (mode == MStuckLow) begin
      force_en  = 1'b1;
      force_val = 1'b0;
    end else if (mode == MStuckHigh) begin
      force_en  = 1'b1;
      force_val = 1'b1;
      idle(4, {tag, "_pre"});
    end

    for (int e = 0; e <= p_last; e++) begin
      start     = (e == 0) || ((e <= p_busy_end) && ($urandom_range(3) == 0)) ||
                  (iso_mode && (e == p_d + 1));
      on_cycles = (e == 0) ? CntW'(n) : CntW'($urandom_range(15));
      stop      = ((mode == MStop) && (e == p_x)) ||
                  (((p_a < 0) || (e <= p_a) || (e > p_x)) && ($urandom_range(3) == 0));
      isolate   = iso_mode && (e >= p_x) && (e <= p_d + 2);
      if (mode == MStuckLow) begin
        err_clr = (e == p_err) || (e == p_clr);
      end else if (mode == MStuckHigh) begin
        err_clr   = (e == p_err + 1) || (e == p_clr);
        force_val = (e < p_err + 2);
      end else begin
        err_clr = ($urandom_range(7) == 0);
      end
      @(posedge ck);
      #1;
      check(tag, e, exp_out(e));
      if (e == stop_at) break;
    end

    start    = 1'b0;
    stop     = 1'b0;
    isolate  = 1'b0;
    err_clr  = 1'b0;
    force_en = 1'b0;
    if (stop_at < 0) idle(4, {tag, "_gap"});
  endtask

  initial begin
    #1 arst_n = 1'b0;
    #1 check("reset", 0, 5'b0);
    @(posedge ck);
    @(negedge ck);
    arst_n = 1'b1;
    idle(2, "post_reset");

    run_window(MNormal, 5, 0, -1, "basic_n5");
    run_window(MStuckLow, 3, 2, -1, "ack_timeout");
    run_window(MNormal, 2, 0, -1, "after_clear");
    run_window(MStop, 100, 10, -1, "stop_at_10");
    run_window(MIsoAct, 20, 6, -1, "iso_active");
    run_window(MZero, 0, 0, -1, "zero_len");
    run_window(MStuckHigh, 4, 0, -1, "drop_timeout");
    run_window(MStop, 6, 6, -1, "stop_on_last");
    run_window(MIsoSettle, 5, S, -1, "iso_settle");

    for (int w = 0; w < 40; w++) begin
      int mode, n, k;
      mode = int'($urandom_range(6));
      n    = int'($urandom_range(12, 1));
      k    = 0;
      if (mode == MStop || mode == MIsoAct) k = int'($urandom_range(n, 1));
      if (mode == MIsoSettle) k = int'($urandom_range(S, 1));
      if (mode == MStuckLow) k = int'($urandom_range(3));
      if (mode == MZero) n = 0;
      run_window(mode, n, k, -1, $sformatf("rnd%0d_m%0d", w, mode));
    end

    // Asynchronous reset three cycles into the on-window.
    run_window(MNormal, 20, 0, S + Y + 2 + 3, "pre_rst");
    #3 arst_n = 1'b0;
    #1 check("async_rst", 0, 5'b0);
    @(posedge ck);
    #1 check("rst_hold", 1, 5'b0);
    @(negedge ck);
    arst_n = 1'b1;
    idle(3, "rst_idle");
    run_window(MNormal, 3, 0, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
